// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout fault.
// Define SINGLE_STEP_EN to add a 'step' port; each step pulse then runs exactly one instruction.
module exec_sequencer #(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     inst,
    input  logic            dec_jump,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_write,
    input  logic [PC_W-1:0] jmp_target,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state,
    output logic [15:0]     instr_cnt,
    output logic            halted,
    output logic            fault
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_inst;
    logic [15:0]       r_cnt;
    logic              r_fault;
    logic [WAIT_W-1:0] r_wait;

    state_t            w_next;
    logic              w_memReq;
    logic              w_memWe;
    logic              w_regWe;
    logic              w_leaveWb;
    logic              w_timeout;
    logic              w_start;

`ifdef SINGLE_STEP_EN
    assign w_start = step;
`else
    assign w_start = run;
`endif

    // A simultaneous load+store is treated as a store: no register write-back.
    always_comb begin
        w_next    = r_state;
        w_memReq  = 1'b0;
        w_memWe   = 1'b0;
        w_regWe   = 1'b0;
        w_leaveWb = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (r_inst == 16'hFFFF) ? S_HALT : S_EXEC;
            S_EXEC:   w_next = (dec_load || dec_store) ? S_MEM : S_WB;
            S_MEM: begin
                w_memReq = 1'b1;
                w_memWe  = dec_store;
                if (mem_ack) begin
                    w_next = S_WB;
                end else if (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    w_next    = S_HALT;
                    w_timeout = 1'b1;
                end
            end
            S_WB: begin
                w_regWe   = (dec_write || dec_load) && !dec_store;
                w_leaveWb = 1'b1;
`ifdef SINGLE_STEP_EN
                w_next    = S_IDLE;
`else
                w_next    = S_FETCH;
`endif
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_inst  <= '0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_inst <= imem_data;
            end
            // Wait counter only runs while a memory access is outstanding.
            if (r_state == S_MEM && !mem_ack) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
            if (w_leaveWb) begin
                r_pc  <= dec_jump ? jmp_target : r_pc + PC_W'(1);
                r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign instr_cnt = r_cnt;
    assign state     = r_state;
    assign fault     = r_fault;
    assign halted    = (r_state == S_HALT);
    assign mem_req   = w_memReq;
    assign mem_we    = w_memWe;
    assign reg_we    = w_regWe;

endmodule
